// File: rtl/aurora_tx_init_ctrl.sv
// aurora_tx_init_ctrl: simplex-TX channel init sequencer and per-cycle block scheduler
// (IDLE/CB/CC/DATA) for the Aurora 64b/66b transmitter.
module aurora_tx_init_ctrl #(
    parameter int MAX_LINKS    = 2,
    parameter int RESET_CYCLES = 16,
    parameter int CB_PERIOD    = 16,
    parameter int CC_PERIOD    = 5000,
    parameter int CC_LEN       = 8,
    parameter int WATCHDOG     = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 single_lane,
    input  logic [MAX_LINKS-1:0] lane_select,
    input  logic                 simplex_aligned,
    input  logic                 simplex_bonded,
    input  logic                 simplex_verified,
    input  logic                 simplex_reset,
    input  logic                 axi_valid,
    output logic                 axi_ready,
    output logic [MAX_LINKS-1:0] lane_en,
    output logic [1:0]           blk_sel,
    output logic                 channel_up,
    output logic [2:0]           init_state
);
    localparam logic [2:0] ST_RST    = 3'd0;
    localparam logic [2:0] ST_ALIGN  = 3'd1;
    localparam logic [2:0] ST_BOND   = 3'd2;
    localparam logic [2:0] ST_VERIFY = 3'd3;
    localparam logic [2:0] ST_READY  = 3'd4;
    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam int BW = $clog2(CB_PERIOD + 1);
    localparam int TW = $clog2(CC_PERIOD + 1);
    localparam int LW = $clog2(CC_LEN + 1);
    localparam int WW = $clog2(WATCHDOG + 1);

    logic [2:0]           state_q, state_d;
    logic [RW-1:0]        rst_cnt_q, rst_cnt_d;
    logic [BW-1:0]        cb_cnt_q, cb_cnt_d;
    logic [TW-1:0]        cc_timer_q, cc_timer_d;
    logic [LW-1:0]        cc_cnt_q, cc_cnt_d;
    logic [WW-1:0]        wd_q, wd_d;
    logic                 single_q, single_d;
    logic [MAX_LINKS-1:0] lane_en_q, lane_en_d;
    logic [MAX_LINKS-1:0] low_bit;
    logic                 cc_active, in_init, wd_expired, rst_done, cc_wrap, to_rst, latch, leave_ready;

    assign cc_active  = cc_cnt_q != '0;
    assign in_init    = state_q == ST_ALIGN || state_q == ST_BOND || state_q == ST_VERIFY;
    assign wd_expired = in_init && wd_q == WW'(WATCHDOG - 1);
    assign rst_done   = state_q == ST_RST && rst_cnt_q == RW'(RESET_CYCLES - 1);
    assign cc_wrap    = state_q != ST_RST && cc_timer_q == TW'(CC_PERIOD - 1);
    assign low_bit    = lane_select == '0 ? MAX_LINKS'(1) : lane_select & (~lane_select + MAX_LINKS'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RST;
            rst_cnt_q  <= '0;
            cb_cnt_q   <= '0;
            cc_timer_q <= '0;
            cc_cnt_q   <= '0;
            wd_q       <= '0;
            single_q   <= 1'b0;
            lane_en_q  <= '0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            cb_cnt_q   <= cb_cnt_d;
            cc_timer_q <= cc_timer_d;
            cc_cnt_q   <= cc_cnt_d;
            wd_q       <= wd_d;
            single_q   <= single_d;
            lane_en_q  <= lane_en_d;
        end
    end

    // Partner reset beats the watchdog, which beats every normal transition.
    always_comb begin
        state_d = state_q;
        if (simplex_reset || wd_expired)
            state_d = ST_RST;
        else
            case (state_q)
                ST_RST:    state_d = rst_done ? ST_ALIGN : ST_RST;
                ST_ALIGN:  state_d = !simplex_aligned ? ST_ALIGN : single_q ? ST_VERIFY : ST_BOND;
                ST_BOND:   state_d = simplex_bonded ? ST_VERIFY : ST_BOND;
                ST_VERIFY: state_d = simplex_verified ? ST_READY : ST_VERIFY;
                ST_READY:  state_d = simplex_aligned ? ST_READY : ST_RST;
                default:   state_d = ST_RST;
            endcase
        to_rst     = state_d == ST_RST;
        latch      = state_q == ST_RST && state_d == ST_ALIGN;
        rst_cnt_d  = (state_q == ST_RST && to_rst && !simplex_reset) ? rst_cnt_q + RW'(1) : '0;
        cb_cnt_d   = (state_q == ST_BOND && state_d == ST_BOND) ?
                     (cb_cnt_q == BW'(CB_PERIOD - 1) ? '0 : cb_cnt_q + BW'(1)) : '0;
        cc_timer_d = (to_rst || state_q == ST_RST || cc_wrap) ? '0 : cc_timer_q + TW'(1);
        cc_cnt_d   = to_rst ? '0 : cc_wrap ? LW'(CC_LEN) : cc_active ? cc_cnt_q - LW'(1) : '0;
        wd_d       = (in_init && (state_d == ST_ALIGN || state_d == ST_BOND || state_d == ST_VERIFY)) ?
                     wd_q + WW'(1) : '0;
        single_d   = latch ? single_lane : single_q;
        lane_en_d  = to_rst ? '0 : latch ? (single_lane ? low_bit : '1) : lane_en_q;
    end

    // A beat is refused in the cycle READY is left so no data straddles the drop.
    always_comb begin
        leave_ready = state_q == ST_READY && (simplex_reset || !simplex_aligned);
        axi_ready   = state_q == ST_READY && !cc_active && !leave_ready;
        blk_sel     = cc_active ? 2'b10 :
                      (state_q == ST_BOND && cb_cnt_q == '0) ? 2'b01 :
                      (axi_valid && axi_ready) ? 2'b11 : 2'b00;
        channel_up  = state_q == ST_READY;
        init_state  = state_q;
        lane_en     = lane_en_q;
    end
endmodule
